// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath with a shared ALU and a shared
//   memory. It steps each instruction through fetch, decode, execute, memory
//   and writeback. It waits on a variable-latency memory and counts retired
//   instructions. On an illegal instruction or a memory timeout it stops in
//   HALT and reports a fault code.
//
// Memory handshake:
//   mem_read / mem_write is the request and mem_ready is the completion.
//   An access finishes in the cycle where the request is high and mem_ready
//   is high. Until that cycle the FSM holds the request and every select
//   steady. When mem_ready is low, a wait counter counts up. If it has already
//   reached MEM_TIMEOUT and mem_ready is still low, the access is abandoned
//   (fault 2'b10) and no strobe is driven in that cycle.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   opcode, funct, zero       IR fields and ALU zero flag
//   mem_ready                 memory completes the current access this cycle
//   pc_en, ir_write, reg_write, mem_read, mem_write
//                             strobes, all forced low while rst is low
//   i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_source
//                             datapath selects
//   state                     current FSM state for debug
//   instr_count               retired-instruction counter (wraps)
//   fault                     00 none, 01 illegal instruction, 10 memory timeout
module multi_cycle_ctrl #(
    parameter int COUNT_W     = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [3:0]         alu_control,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count,
    output logic [1:0]         fault
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_R_WB    = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_I_EXEC  = 4'd10,
        S_I_WB    = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // The counter only needs to reach MEM_TIMEOUT; it saturates at all-ones.
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    // R-type funct decode: {legal, alu_src_a, alu_control}.
    function automatic logic [6:0] r_decode(input logic [5:0] f);
        case (f)
            6'b100000: r_decode = {1'b1, 2'b01, ALU_ADD};
            6'b100010: r_decode = {1'b1, 2'b01, ALU_SUB};
            6'b100100: r_decode = {1'b1, 2'b01, ALU_AND};
            6'b100101: r_decode = {1'b1, 2'b01, ALU_OR};
            6'b100110: r_decode = {1'b1, 2'b01, ALU_XOR};
            6'b100111: r_decode = {1'b1, 2'b01, ALU_NOR};
            6'b101010: r_decode = {1'b1, 2'b01, ALU_SLT};
            6'b000000: r_decode = {1'b1, 2'b10, ALU_SLL};
            6'b000010: r_decode = {1'b1, 2'b10, ALU_SRL};
            6'b000011: r_decode = {1'b1, 2'b10, ALU_SRA};
            default:   r_decode = 7'b0;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          fault_q, fault_d;
    logic [COUNT_W-1:0]  count_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [6:0]          r_dec;
    logic                wait_st;
    logic                at_limit;

    logic       pc_en_r, i_or_d_r, mem_read_r, mem_write_r, ir_write_r;
    logic       reg_dst_r, mem_to_reg_r, reg_write_r;
    logic [1:0] src_a_r, src_b_r, pc_source_r;
    logic [3:0] alu_r;

    assign r_dec    = r_decode(funct);
    assign at_limit = (MEM_TIMEOUT != 0) && (wait_q >= TIMEOUT_V);

    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        wait_st      = 1'b0;
        pc_en_r      = 1'b0;
        i_or_d_r     = 1'b0;
        mem_read_r   = 1'b0;
        mem_write_r  = 1'b0;
        ir_write_r   = 1'b0;
        reg_dst_r    = 1'b0;
        mem_to_reg_r = 1'b0;
        reg_write_r  = 1'b0;
        src_a_r      = 2'b00;
        src_b_r      = 2'b00;
        alu_r        = ALU_AND;
        pc_source_r  = 2'b00;

        case (state_q)
            S_FETCH: begin
                wait_st    = 1'b1;
                mem_read_r = 1'b1;
                src_b_r    = 2'b01;
                alu_r      = ALU_ADD;
                if (mem_ready) begin
                    ir_write_r = 1'b1;
                    pc_en_r    = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut.
                src_b_r = 2'b11;
                alu_r   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADR;
                    OP_RTYPE:        state_d = S_R_EXEC;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    default: begin
                        state_d = S_HALT;
                        fault_d = 2'b01;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a_r = 2'b01;
                src_b_r = 2'b10;
                alu_r   = ALU_ADD;
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                wait_st    = 1'b1;
                i_or_d_r   = 1'b1;
                mem_read_r = 1'b1;
                src_a_r    = 2'b01;
                src_b_r    = 2'b10;
                alu_r      = ALU_ADD;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg_r = 1'b1;
                reg_write_r  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                wait_st     = 1'b1;
                i_or_d_r    = 1'b1;
                mem_write_r = 1'b1;
                src_a_r     = 2'b01;
                src_b_r     = 2'b10;
                alu_r       = ALU_ADD;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                if (r_dec[6]) begin
                    src_a_r = r_dec[5:4];
                    alu_r   = r_dec[3:0];
                    state_d = S_R_WB;
                end else begin
                    state_d = S_HALT;
                    fault_d = 2'b01;
                end
            end
            S_R_WB: begin
                // funct is still in IR, so re-decoding holds the R_EXEC controls.
                reg_dst_r   = 1'b1;
                reg_write_r = 1'b1;
                src_a_r     = r_dec[5:4];
                alu_r       = r_dec[3:0];
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_r     = 2'b01;
                alu_r       = ALU_SUB;
                pc_source_r = 2'b01;
                pc_en_r     = zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_source_r = 2'b10;
                pc_en_r     = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC, S_I_WB: begin
                src_a_r     = 2'b01;
                src_b_r     = 2'b10;
                alu_r       = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                reg_write_r = (state_q == S_I_WB);
                state_d     = (state_q == S_I_WB) ? S_FETCH : S_I_WB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Abandon the access: no strobe fires in the timeout cycle.
        if (wait_st && !mem_ready && at_limit) begin
            state_d     = S_HALT;
            fault_d     = 2'b10;
            mem_read_r  = 1'b0;
            mem_write_r = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            fault_q <= 2'b00;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            // A return to FETCH from any other state retires one instruction.
            if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_HALT)
                count_q <= count_q + 1'b1;
            if (state_d != state_q)
                wait_q <= '0;
            else if (wait_st && !mem_ready && wait_q != {WAIT_W{1'b1}})
                wait_q <= wait_q + 1'b1;
        end
    end

    // Gating with rst makes every output drop the moment reset is asserted,
    // so an aborted instruction can never issue a partial write.
    assign pc_en       = rst & pc_en_r;
    assign i_or_d      = rst & i_or_d_r;
    assign mem_read    = rst & mem_read_r;
    assign mem_write   = rst & mem_write_r;
    assign ir_write    = rst & ir_write_r;
    assign reg_dst     = rst & reg_dst_r;
    assign mem_to_reg  = rst & mem_to_reg_r;
    assign reg_write   = rst & reg_write_r;
    assign alu_src_a   = rst ? src_a_r : 2'b00;
    assign alu_src_b   = rst ? src_b_r : 2'b00;
    assign alu_control = rst ? alu_r : 4'b0000;
    assign pc_source   = rst ? pc_source_r : 2'b00;
    assign state       = state_q;
    assign instr_count = count_q;
    assign fault       = fault_q;

endmodule
